// File: rtl/wb_req_bridge_if.sv
// Signal bundle for wb_req_bridge: Wishbone classic slave side plus the
// request / write-stream / read-stream side toward the target.
interface wb_req_bridge_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [3:0]  wb_sel_i;
   logic [29:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_ack_o;

   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_mask;
   logic [31:0] req_addr;
   logic [2:0]  req_len;
   logic        req_we;
   logic        req_wrap;

   logic        write_valid;
   logic [31:0] write_data;

   logic        read_valid;
   logic [31:0] read_data;
   logic        read_ack;

   // Bridge view.
   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
      input  req_ready, read_valid, read_data,
      output wb_dat_o, wb_ack_o,
      output req_valid, req_mask, req_addr, req_len, req_we, req_wrap,
      output write_valid, write_data, read_ack
   );

   // Environment view: Wishbone master plus request-protocol target.
   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
      output req_ready, read_valid, read_data,
      input  wb_dat_o, wb_ack_o,
      input  req_valid, req_mask, req_addr, req_len, req_we, req_wrap,
      input  write_valid, write_data, read_ack
   );
endinterface

// File: rtl/wb_req_bridge.sv
// Wishbone classic slave -> request/write-stream/read-stream bridge, one transaction at a time.
// Define WB_REQ_PREFETCH_EN to add a 4-word line buffer that serves repeated reads in a 16-byte line.
module wb_req_bridge (
   input  logic           clk_i,
   input  logic           rst_ni,
   wb_req_bridge_if.slave bus,
   output logic [2:0]     dbg_state
);

   // Handshakes: req_* is offered while req_valid and held stable until a cycle with
   // req_valid & req_ready; write_valid and wb_ack_o are single-cycle pulses without
   // back-pressure; a read beat is consumed in each cycle with read_valid & read_ack.

`ifdef WB_REQ_PREFETCH_EN
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WDATA = 3'd2,
      S_RWAIT = 3'd3,
      S_ACK   = 3'd4,
      S_FILL  = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WDATA = 3'd2,
      S_RWAIT = 3'd3,
      S_ACK   = 3'd4
   } state_t;
`endif

   state_t      state_q, state_d;
   logic        start;
   logic        rd_hit;
   logic        line_miss;
   logic [31:0] line_rd;
   logic        rd_phase;
   logic        read_ack;
   logic        aborted_q;

   logic [31:0] dat_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  mask_q;
   logic [2:0]  len_q;
   logic        we_q;
   logic        wrap_q;

   assign start    = (state_q == S_IDLE) && bus.wb_cyc_i && bus.wb_stb_i;
   assign read_ack = bus.read_valid && rd_phase;

`ifdef WB_REQ_PREFETCH_EN
   logic [31:0] line_q [4];
   logic [27:0] tag_q;
   logic [3:0]  vld_q;
   logic [1:0]  fill_idx_q;
   logic [1:0]  beats_left_q;
   logic        tag_hit;
   logic        word_vld;
   logic        more_beats;
   logic        last_beat;

   assign tag_hit    = (tag_q == bus.wb_adr_i[29:2]);
   assign word_vld   = vld_q[bus.wb_adr_i[1:0]];
   assign rd_hit     = !bus.wb_we_i && tag_hit && word_vld;
   assign line_miss  = !bus.wb_we_i && !rd_hit;
   assign line_rd    = line_q[bus.wb_adr_i[1:0]];
   assign rd_phase   = (state_q == S_RWAIT) || (state_q == S_FILL);
   assign more_beats = (beats_left_q != 2'd0);
   assign last_beat  = (beats_left_q == 2'd1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 4; i++) line_q[i] <= '0;
         tag_q        <= '0;
         vld_q        <= '0;
         fill_idx_q   <= '0;
         beats_left_q <= '0;
      end else begin
         // A miss restarts the line; the wrapped burst begins at the requested word.
         if (start && line_miss) begin
            vld_q      <= '0;
            tag_q      <= bus.wb_adr_i[29:2];
            fill_idx_q <= bus.wb_adr_i[1:0];
         end
         if (start && bus.wb_we_i && tag_hit && word_vld) begin
            for (int b = 0; b < 4; b++) begin
               if (bus.wb_sel_i[b])
                  line_q[bus.wb_adr_i[1:0]][8*b +: 8] <= bus.wb_dat_i[8*b +: 8];
            end
         end
         if (read_ack) begin
            line_q[fill_idx_q] <= bus.read_data;
            vld_q[fill_idx_q]  <= 1'b1;
            fill_idx_q         <= fill_idx_q + 2'd1;
         end
         if ((state_q == S_RWAIT) && bus.read_valid)
            beats_left_q <= len_q[1:0] - 2'd1;
         else if ((state_q == S_FILL) && bus.read_valid)
            beats_left_q <= beats_left_q - 2'd1;
      end
   end
`else
   assign rd_hit    = 1'b0;
   assign line_miss = 1'b0;
   assign line_rd   = '0;
   assign rd_phase  = (state_q == S_RWAIT);
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = rd_hit ? S_ACK : S_REQ;
         S_REQ:   if (bus.req_ready) state_d = we_q ? S_WDATA : S_RWAIT;
         S_WDATA: state_d = S_ACK;
         S_RWAIT: if (bus.read_valid) state_d = S_ACK;
`ifdef WB_REQ_PREFETCH_EN
         S_ACK:   state_d = more_beats ? S_FILL : S_IDLE;
         S_FILL:  if (bus.read_valid && last_beat) state_d = S_IDLE;
`else
         S_ACK:   state_d = S_IDLE;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dat_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         mask_q    <= '0;
         len_q     <= '0;
         we_q      <= 1'b0;
         wrap_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         if (start) begin
            aborted_q <= 1'b0;
            addr_q    <= {bus.wb_adr_i, 2'b00};
            we_q      <= bus.wb_we_i;
            wdata_q   <= bus.wb_dat_i;
            if (line_miss) begin
               mask_q <= 4'hF;
               len_q  <= 3'd4;
               wrap_q <= 1'b1;
            end else begin
               mask_q <= bus.wb_sel_i;
               len_q  <= 3'd1;
               wrap_q <= 1'b0;
            end
            if (rd_hit) dat_q <= line_rd;
         end
         // A master that gives up mid-transaction must not receive the late ack.
         if (((state_q == S_REQ) || (state_q == S_WDATA) || (state_q == S_RWAIT)) && !bus.wb_cyc_i)
            aborted_q <= 1'b1;
         if ((state_q == S_RWAIT) && bus.read_valid)
            dat_q <= bus.read_data;
      end
   end

   assign bus.wb_dat_o    = dat_q;
   assign bus.wb_ack_o    = (state_q == S_ACK) && bus.wb_cyc_i && !aborted_q;
   assign bus.req_valid   = (state_q == S_REQ);
   assign bus.req_mask    = mask_q;
   assign bus.req_addr    = addr_q;
   assign bus.req_len     = len_q;
   assign bus.req_we      = we_q;
   assign bus.req_wrap    = wrap_q;
   assign bus.write_valid = (state_q == S_WDATA);
   assign bus.write_data  = wdata_q;
   assign bus.read_ack    = read_ack;
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_wb_req_bridge.sv
// Directed self-checking bench for wb_req_bridge (default build; extra steps when
// WB_REQ_PREFETCH_EN is defined).
module tb_wb_req_bridge;

   logic       clk = 1'b0;
   logic       rst_ni;
   logic [2:0] dbg_state;

   wb_req_bridge_if bus ();

   wb_req_bridge dut (
      .clk_i     (clk),
      .rst_ni    (rst_ni),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

`ifdef WB_REQ_PREFETCH_EN
   localparam bit PF = 1'b1;
`else
   localparam bit PF = 1'b0;
`endif

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // ---------------- monitor (samples on the falling edge) ----------------
   int          ack_cnt  = 0;
   int          wv_cnt   = 0;
   int          rack_cnt = 0;
   int          rv_cnt   = 0;
   logic [31:0] wv_data  = '0;

   always @(negedge clk) begin
      if (bus.wb_ack_o)    ack_cnt  <= ack_cnt + 1;
      if (bus.read_ack)    rack_cnt <= rack_cnt + 1;
      if (bus.req_valid)   rv_cnt   <= rv_cnt + 1;
      if (bus.write_valid) begin
         wv_cnt  <= wv_cnt + 1;
         wv_data <= bus.write_data;
      end
   end

   // ---------------- scoreboard ----------------
   int          pass_cnt = 0;
   int          fail_cnt = 0;
   int          chk_cnt  = 0;
   logic [31:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- request-side target model ----------------
   int          rsp_ready_dly = 0;
   int          rsp_read_gap  = 0;
   logic [31:0] rsp_beats [4];
   int          hs_cnt      = 0;
   logic [31:0] cap_addr    = '0;
   logic [3:0]  cap_mask    = '0;
   logic [2:0]  cap_len     = '0;
   logic        cap_we      = 1'b0;
   logic        cap_wrap    = 1'b0;
   logic        rsp_timeout = 1'b0;

   initial begin : responder
      int n;
      int t;
      bus.req_ready  = 1'b0;
      bus.read_valid = 1'b0;
      bus.read_data  = '0;
      forever begin
         @(negedge clk);
         if (rst_ni && bus.req_valid) begin
            n = 0;
            while (n < rsp_ready_dly && rst_ni) begin
               @(negedge clk);
               n++;
            end
            if (rst_ni) begin
               bus.req_ready = 1'b1;
               hs_cnt++;
               cap_addr = bus.req_addr;
               cap_mask = bus.req_mask;
               cap_len  = bus.req_len;
               cap_we   = bus.req_we;
               cap_wrap = bus.req_wrap;
               @(posedge clk); #1;
               bus.req_ready = 1'b0;
               if (!cap_we) begin
                  for (int i = 0; i < rsp_read_gap; i++) begin
                     @(posedge clk); #1;
                  end
                  for (int b = 0; b < int'(cap_len) && b < 4; b++) begin
                     bus.read_valid = 1'b1;
                     bus.read_data  = rsp_beats[b];
                     t = 0;
                     do begin
                        @(negedge clk);
                        t++;
                     end while (!bus.read_ack && t < 60);
                     if (!bus.read_ack) rsp_timeout = 1'b1;
                     @(posedge clk); #1;
                  end
                  bus.read_valid = 1'b0;
               end
            end
         end
      end
   end

   // ---------------- Wishbone master driver ----------------
   task automatic wb_xfer(input logic we, input logic [29:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output int lat, output logic [31:0] rdat);
      int start;
      @(posedge clk); #1;
      start          = cyc_cnt;
      bus.wb_cyc_i   = 1'b1;
      bus.wb_stb_i   = 1'b1;
      bus.wb_we_i    = we;
      bus.wb_adr_i   = adr;
      bus.wb_dat_i   = dat;
      bus.wb_sel_i   = sel;
      lat            = -1;
      rdat           = '0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.wb_ack_o) begin
            lat  = cyc_cnt - start;
            rdat = bus.wb_dat_o;
            break;
         end
      end
      @(posedge clk); #1;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin : main
      int          lat;
      logic [31:0] rdat;
      int          hs0, wv0, ack0, rack0, rv0;

      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      bus.wb_adr_i = '0;
      bus.wb_dat_i = '0;
      bus.wb_sel_i = '0;
      for (int i = 0; i < 4; i++) rsp_beats[i] = '0;
      rst_ni = 1'b0;

      // Reset values.
      repeat (3) @(posedge clk); #1;
      check("rst_state",       32'(dbg_state),       32'd0);
      check("rst_req_valid",   32'(bus.req_valid),   32'd0);
      check("rst_write_valid", 32'(bus.write_valid), 32'd0);
      check("rst_ack",         32'(bus.wb_ack_o),    32'd0);
      check("rst_read_ack",    32'(bus.read_ack),    32'd0);
      check("rst_dat",         bus.wb_dat_o,         32'h0);
      check("rst_addr",        bus.req_addr,         32'h0);
      check("rst_mask",        32'(bus.req_mask),    32'h0);
      check("rst_len",         32'(bus.req_len),     32'h0);
      check("rst_wdata",       bus.write_data,       32'h0);
      rst_ni = 1'b1;
      repeat (2) @(posedge clk);

      // Write 0x100 <- DEADBEEF, ready immediately.
      rsp_ready_dly = 0;
      rsp_read_gap  = 0;
      hs0 = hs_cnt; wv0 = wv_cnt; ack0 = ack_cnt;
      exp_q.push_back(32'hDEADBEEF);
      wb_xfer(1'b1, 30'h100, 32'hDEADBEEF, 4'hF, lat, rdat);
      repeat (2) @(posedge clk); #1;
      check("wr_lat",   32'(lat),            32'd3);
      check("wr_addr",  cap_addr,            32'h400);
      check("wr_we",    32'(cap_we),         32'd1);
      check("wr_len",   32'(cap_len),        32'd1);
      check("wr_mask",  32'(cap_mask),       32'hF);
      check("wr_hs",    32'(hs_cnt - hs0),   32'd1);
      check("wr_beats", 32'(wv_cnt - wv0),   32'd1);
      check("wr_data",  wv_data,             exp_q.pop_front());
      check("wr_acks",  32'(ack_cnt - ack0), 32'd1);

      // Read 0x20, ready after 3 cycles, beat 5 cycles after the handshake.
      rsp_ready_dly = 3;
      rsp_read_gap  = 4;
      rsp_beats[0] = 32'h12345678;
      rsp_beats[1] = 32'h11111111;
      rsp_beats[2] = 32'h22222222;
      rsp_beats[3] = 32'h33333333;
      rack0 = rack_cnt; ack0 = ack_cnt;
      wb_xfer(1'b0, 30'h20, 32'h0, 4'h3, lat, rdat);
      repeat (10) @(posedge clk); #1;
      check("rd_lat",   32'(lat),              32'd10);
      check("rd_data",  rdat,                  32'h12345678);
      check("rd_addr",  cap_addr,              32'h80);
      check("rd_we",    32'(cap_we),           32'd0);
      check("rd_len",   32'(cap_len),          PF ? 32'd4 : 32'd1);
      check("rd_mask",  32'(cap_mask),         PF ? 32'hF : 32'h3);
      check("rd_wrap",  32'(cap_wrap),         PF ? 32'd1 : 32'd0);
      check("rd_racks", 32'(rack_cnt - rack0), PF ? 32'd4 : 32'd1);
      check("rd_acks",  32'(ack_cnt - ack0),   32'd1);

      // Read 0x30 abandoned by the master while the bridge waits for the beat.
      rsp_ready_dly = 0;
      rsp_read_gap  = 6;
      rsp_beats[0]  = 32'hCAFE0001;
      hs0 = hs_cnt; rack0 = rack_cnt; ack0 = ack_cnt;
      @(posedge clk); #1;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = 1'b0;
      bus.wb_adr_i = 30'h30;
      bus.wb_sel_i = 4'hF;
      repeat (3) @(posedge clk); #1;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      repeat (15) @(posedge clk); #1;
      check("ab_acks",  32'(ack_cnt - ack0),   32'd0);
      check("ab_racks", 32'(rack_cnt - rack0), PF ? 32'd4 : 32'd1);
      check("ab_hs",    32'(hs_cnt - hs0),     32'd1);
      check("ab_state", 32'(dbg_state),        32'd0);

      // Following write completes normally; ready after 2 cycles.
      rsp_ready_dly = 2;
      ack0 = ack_cnt;
      exp_q.push_back(32'h0BADF00D);
      wb_xfer(1'b1, 30'h44, 32'h0BADF00D, 4'h5, lat, rdat);
      repeat (2) @(posedge clk); #1;
      check("wr2_lat",  32'(lat),            32'd5);
      check("wr2_addr", cap_addr,            32'h110);
      check("wr2_mask", 32'(cap_mask),       32'h5);
      check("wr2_data", wv_data,             exp_q.pop_front());
      check("wr2_acks", 32'(ack_cnt - ack0), 32'd1);

      // Asynchronous reset while the request is pending.
      rsp_ready_dly = 20;
      hs0 = hs_cnt;
      @(posedge clk); #1;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = 1'b1;
      bus.wb_adr_i = 30'h77;
      bus.wb_dat_i = 32'h55AA55AA;
      bus.wb_sel_i = 4'hF;
      repeat (2) @(posedge clk); #2;
      check("ar_pre_state", 32'(dbg_state),     32'd1);
      check("ar_pre_valid", 32'(bus.req_valid), 32'd1);
      rst_ni = 1'b0;
      #1;
      check("ar_req_valid", 32'(bus.req_valid), 32'd0);
      check("ar_ack",       32'(bus.wb_ack_o),  32'd0);
      check("ar_state",     32'(dbg_state),     32'd0);
      check("ar_addr",      bus.req_addr,       32'h0);
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      repeat (2) @(posedge clk); #1;
      rst_ni = 1'b1;
      rv0 = rv_cnt;
      repeat (25) @(posedge clk); #1;
      check("ar_no_req",  32'(rv_cnt - rv0),  32'd0);
      check("ar_no_hs",   32'(hs_cnt - hs0),  32'd0);
      check("ar_idle",    32'(dbg_state),     32'd0);
      rsp_ready_dly = 0;

`ifdef WB_REQ_PREFETCH_EN
      // Line miss at 0x12: wrapped burst of 4 starting at word 2.
      rsp_read_gap = 0;
      rsp_beats[0] = 32'hA2;
      rsp_beats[1] = 32'hA3;
      rsp_beats[2] = 32'hA0;
      rsp_beats[3] = 32'hA1;
      wb_xfer(1'b0, 30'h12, 32'h0, 4'hF, lat, rdat);
      repeat (8) @(posedge clk); #1;
      check("pf_miss_lat",  32'(lat),        32'd3);
      check("pf_miss_data", rdat,            32'hA2);
      check("pf_miss_addr", cap_addr,        32'h48);
      check("pf_miss_len",  32'(cap_len),    32'd4);
      check("pf_miss_wrap", 32'(cap_wrap),   32'd1);
      check("pf_miss_mask", 32'(cap_mask),   32'hF);

      // Hit on word 0 of the same line: no request.
      hs0 = hs_cnt; rv0 = rv_cnt;
      wb_xfer(1'b0, 30'h10, 32'h0, 4'hF, lat, rdat);
      repeat (2) @(posedge clk); #1;
      check("pf_hit_lat",  32'(lat),           32'd1);
      check("pf_hit_data", rdat,               32'hA0);
      check("pf_hit_hs",   32'(hs_cnt - hs0),  32'd0);
      check("pf_hit_rv",   32'(rv_cnt - rv0),  32'd0);

      // Partial write into a buffered word is forwarded and merged.
      hs0 = hs_cnt;
      wb_xfer(1'b1, 30'h11, 32'hFFFF5555, 4'h3, lat, rdat);
      repeat (2) @(posedge clk); #1;
      check("pf_wr_lat",  32'(lat),          32'd3);
      check("pf_wr_hs",   32'(hs_cnt - hs0), 32'd1);
      check("pf_wr_len",  32'(cap_len),      32'd1);
      wb_xfer(1'b0, 30'h11, 32'h0, 4'hF, lat, rdat);
      repeat (2) @(posedge clk); #1;
      check("pf_merge_lat",  32'(lat), 32'd1);
      check("pf_merge_data", rdat,     32'h00005555);
`endif

      check("rsp_timeout", 32'(rsp_timeout), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/wb_req_bridge.md
# wb_req_bridge

Wishbone classic slave that converts each bus cycle into a transaction on the team's internal request/write-stream/read-stream interface. It is the responder-side counterpart of the request-to-Wishbone master bridge: Wishbone masters (CPU glue, debug) reach request-protocol targets (memory controller, DMA-visible buffers) through it. It handles one transaction at a time. An optional line buffer serves repeated reads within the same 16-byte line.

## Interface
- No parameters; AW=32, DW=32, COLS=4 fixed.
- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  Wishbone strobe
- wb_we_i  in  1  write enable
- wb_sel_i  in  4  byte selects
- wb_adr_i  in  30  word address
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, registered
- wb_ack_o  out  1  acknowledge, one-cycle pulse
- req_valid  out  1  request valid
- req_ready  in  1  request accepted when req_valid & req_ready
- req_mask  out  4  byte mask
- req_addr  out  32  byte address ({adr,2'b00})
- req_len  out  3  beat count
- req_we  out  1  write request
- req_wrap  out  1  wrap within 4-word line
- write_valid  out  1  write beat, one-cycle pulse
- write_data  out  32  write beat data
- read_valid  in  1  read beat available (show-ahead)
- read_data  in  32  read beat data
- read_ack  out  1  consume read beat, combinational

## Operation
- States: IDLE, REQ, WDATA, RWAIT, ACK, FILL (FILL only with prefetch).
- IDLE: on wb_cyc_i & wb_stb_i, latch we/sel/adr/dat, drive req_* and go to REQ. Without prefetch, req_len=1, req_wrap=0, req_mask=wb_sel_i.
- REQ: hold req_valid=1 and all req_* stable until req_ready. Write: go to WDATA. Read: go to RWAIT.
- WDATA: write_valid=1 with the latched data for exactly one cycle, then go to ACK.
- RWAIT: read_ack = read_valid. On a beat, load wb_dat_o <= read_data and go to ACK.
- ACK: wb_ack_o=1 for one cycle, then go to IDLE (or FILL if beats remain).
- Abort: if wb_cyc_i is low in ACK, wb_ack_o is suppressed. The downstream transaction always completes and all of its beats are consumed.
- Reset, at any time: IDLE; req_valid, write_valid, wb_ack_o = 0; wb_dat_o, req_addr, req_mask, req_len, write_data = 0; line buffer invalid. read_ack = 0 because the state is IDLE.

## Timing
- Write: stb sampled in cycle 0; req_valid in cycles 1..k (k = first cycle with req_ready); write_valid in k+1; wb_ack_o in k+2. Minimum 3 cycles from stb to ack.
- Read: read_valid seen in cycle r (r > k); wb_ack_o in r+1.
- The master drops stb in the cycle after ack. IDLE never re-triggers on a stb that has already been acknowledged.
- Exactly one wb_ack_o per non-aborted cycle.
- Exactly one read_ack per read beat. No read_ack outside RWAIT/FILL.

## Configuration
- WB_REQ_PREFETCH_EN defined: adds a 4×32 line buffer with a 28-bit tag (adr[29:2]) and valid[3:0].
  - Read hit (tag match and valid[adr[1:0]]): IDLE goes straight to ACK with buffer data, so ack comes 1 cycle after stb, with no request.
  - Read miss: req_len=4, req_wrap=1, req_mask=4'hF, req_addr={adr,2'b00}. Clear valid and set tag. Beats fill words adr[1:0], +1, +2, +3 (mod 4). The first beat goes to wb_dat_o, then ACK. FILL consumes the remaining 3 beats; new WB cycles wait in IDLE-pending until FILL completes.
  - Write: always forwarded with len=1. On a tag hit, valid words are byte-merged per wb_sel_i.
- WB_REQ_PREFETCH_EN undefined: no buffer and no FILL state; every read is len=1 with req_mask=wb_sel_i.

## Test plan
- Write adr 0x100, dat 0xDEADBEEF, sel 0xF, req_ready immediate -> req_addr 0x400, req_we=1, req_len=1, mask 0xF; one write_valid with 0xDEADBEEF; wb_ack_o 3 cycles after stb.
- Read adr 0x20, req_ready delayed 3 cycles, read_valid 5 cycles after the handshake with 0x12345678 -> wb_dat_o=0x12345678; one read_ack, one wb_ack_o.
- Read in which wb_cyc_i drops during RWAIT -> no wb_ack_o; beat still consumed; next write completes normally.
- rst_ni low while in REQ -> req_valid and wb_ack_o low immediately (asynchronously); after release, IDLE and no spurious request.
- Prefetch: read adr 0x12 -> req_addr 0x48, len 4, wrap 1; beats 0xA2, 0xA3, 0xA0, 0xA1 give wb_dat_o=0xA2. Then read adr 0x10 -> 0xA0 acked 1 cycle after stb, with no req_valid.
- Prefetch: write adr 0x11, sel 0x3, dat 0xFFFF5555 over 0xA1 -> forwarded; subsequent read 0x11 returns 0x00005555 merged with buffer upper bytes (0x0000 from 0x000000A1) = 0x00005555.
